// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with per-register rename busy/tag tracking
module reg_file #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int ROB_W   = 4,
  localparam int IDX_W  = $clog2(REG_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             issue_en,
  input  logic [IDX_W-1:0] issue_rd,
  input  logic [ROB_W-1:0] issue_rob_id,
  input  logic [IDX_W-1:0] rs1_id,
  input  logic [IDX_W-1:0] rs2_id,
  output logic [XLEN-1:0]  rs1_val,
  output logic             rs1_busy,
  output logic [ROB_W-1:0] rs1_tag,
  output logic [XLEN-1:0]  rs2_val,
  output logic             rs2_busy,
  output logic [ROB_W-1:0] rs2_tag,
  input  logic             commit_en,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [IDX_W-1:0] commit_rd,
  input  logic [XLEN-1:0]  commit_val
);

  logic [XLEN-1:0]    val_q [REG_NUM];
  logic [ROB_W-1:0]   tag_q [REG_NUM];
  logic [REG_NUM-1:0] busy_q;

  logic commit_wr;
  logic commit_owns;
  logic issue_wr;

  assign commit_wr   = commit_en && (commit_rd != '0);
  assign commit_owns = busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_id);
  assign issue_wr    = issue_en && (issue_rd != '0) && !clear;

  // Issue is applied after commit so a same-cycle rename to the same rd wins busy/tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else if (rdy) begin
      if (clear)
        busy_q <= '0;
      if (commit_wr) begin
        val_q[commit_rd] <= commit_val;
        if (commit_owns)
          busy_q[commit_rd] <= 1'b0;
      end
      if (issue_wr) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_id;
      end
    end
  end

  // Reads see pre-rename state, with the committing value forwarded to its owner.
  always_comb begin
    rs1_val  = val_q[rs1_id];
    rs1_busy = busy_q[rs1_id];
    rs1_tag  = tag_q[rs1_id];
    if (rs1_id == '0) begin
      rs1_val  = '0;
      rs1_busy = 1'b0;
      rs1_tag  = '0;
    end else if (commit_en && (commit_rd == rs1_id) && busy_q[rs1_id] &&
                 (tag_q[rs1_id] == commit_rob_id)) begin
      rs1_val  = commit_val;
      rs1_busy = 1'b0;
    end
  end

  always_comb begin
    rs2_val  = val_q[rs2_id];
    rs2_busy = busy_q[rs2_id];
    rs2_tag  = tag_q[rs2_id];
    if (rs2_id == '0) begin
      rs2_val  = '0;
      rs2_busy = 1'b0;
      rs2_tag  = '0;
    end else if (commit_en && (commit_rd == rs2_id) && busy_q[rs2_id] &&
                 (tag_q[rs2_id] == commit_rob_id)) begin
      rs2_val  = commit_val;
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed bench for reg_file
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_id;
  logic [4:0]  rs1_id, rs2_id;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;
  logic        commit_en;
  logic [3:0]  commit_rob_id;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
    .commit_en(commit_en), .commit_rob_id(commit_rob_id),
    .commit_rd(commit_rd), .commit_val(commit_val)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
    issue_en = 1'b1; issue_rd = rd; issue_rob_id = tag;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] v);
    commit_en = 1'b1; commit_rd = rd; commit_rob_id = tag; commit_val = v;
  endtask

  task automatic idle();
    issue_en = 1'b0; commit_en = 1'b0; clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    issue_en = 1'b0; issue_rd = '0; issue_rob_id = '0;
    commit_en = 1'b0; commit_rd = '0; commit_rob_id = '0; commit_val = '0;
    rs1_id = '0; rs2_id = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state and x0
    rs1_id = 5; rs2_id = 0; #1;
    check("rst_rs1_val", rs1_val, 0);
    check("rst_rs1_busy", rs1_busy, 0);
    check("rst_rs1_tag", rs1_tag, 0);
    check("rst_rs2_val", rs2_val, 0);
    check("rst_rs2_busy", rs2_busy, 0);
    commit(0, 0, 32'hDEAD); tick(); idle();
    rs1_id = 0; #1;
    check("x0_val", rs1_val, 0);

    // rename then commit with bypass
    issue(3, 7); tick(); idle();
    rs1_id = 3; #1;
    check("x3_busy", rs1_busy, 1);
    check("x3_tag", rs1_tag, 7);
    commit(3, 7, 32'h1234); #1;
    check("x3_byp_busy", rs1_busy, 0);
    check("x3_byp_val", rs1_val, 32'h1234);
    tick(); idle(); #1;
    check("x3_st_busy", rs1_busy, 0);
    check("x3_st_val", rs1_val, 32'h1234);

    // older producer commits after younger rename
    issue(4, 2); tick(); issue(4, 5); tick(); idle();
    commit(4, 2, 32'h11); rs1_id = 4; #1;
    check("x4_old_nobyp_busy", rs1_busy, 1);
    tick(); idle(); #1;
    check("x4_old_val", rs1_val, 32'h11);
    check("x4_old_busy", rs1_busy, 1);
    check("x4_old_tag", rs1_tag, 5);
    commit(4, 5, 32'h22); rs2_id = 4; #1;
    check("x4_byp_busy", rs2_busy, 0);
    check("x4_byp_val", rs2_val, 32'h22);
    tick(); idle(); #1;
    check("x4_busy", rs2_busy, 0);
    check("x4_val", rs2_val, 32'h22);

    // same-cycle commit and issue on one rd
    issue(6, 1); tick(); idle();
    commit(6, 1, 32'hAA); issue(6, 9); rs1_id = 6; #1;
    check("x6_pre_busy", rs1_busy, 0);
    check("x6_pre_val", rs1_val, 32'hAA);
    check("x6_pre_tag", rs1_tag, 1);
    tick(); idle(); #1;
    check("x6_busy", rs1_busy, 1);
    check("x6_tag", rs1_tag, 9);
    check("x6_val", rs1_val, 32'hAA);

    // flush with concurrent commit and issue
    for (int i = 1; i <= 10; i++) begin
      issue(i[4:0], 4'(i - 1)); tick();
    end
    idle();
    clear = 1'b1; commit(2, 1, 32'h55); issue(11, 10); tick(); idle();
    for (int i = 1; i <= 11; i++) begin
      rs1_id = i[4:0]; #1;
      check($sformatf("clr_busy_x%0d", i), rs1_busy, 0);
    end
    rs1_id = 2; rs2_id = 3; #1;
    check("clr_x2_val", rs1_val, 32'h55);
    check("clr_x3_val", rs2_val, 32'h1234);
    check("clr_x3_tag", rs2_tag, 2);

    // hold with rdy low
    issue(5, 3); tick(); idle();
    rdy = 1'b0; issue(5, 12); commit(5, 3, 32'h77); clear = 1'b1; rs1_id = 5; #1;
    check("hold_byp_val", rs1_val, 32'h77);
    tick(); idle(); #1;
    check("hold_busy", rs1_busy, 1);
    check("hold_tag", rs1_tag, 3);
    check("hold_val", rs1_val, 0);
    rdy = 1'b1; #1;
    check("resume_busy", rs1_busy, 1);
    check("resume_tag", rs1_tag, 3);

    // reset with outstanding renames
    issue(7, 4); rst = 1'b1; tick(); rst = 1'b0; idle();
    rs1_id = 5; rs2_id = 2; #1;
    check("rst2_x5_busy", rs1_busy, 0);
    check("rst2_x5_tag", rs1_tag, 0);
    check("rst2_x2_val", rs2_val, 0);
    rs1_id = 7; #1;
    check("rst2_x7_busy", rs1_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
